// File: rtl/goertzel_power.sv
// Single-bin Goertzel power detector: accumulates N samples through the s1/s2
// recursion, then spends three cycles turning the final state into a saturated power word.
module goertzel_power #(
    parameter int unsigned        N           = 256,
    parameter int unsigned        SAMPLE_W    = 12,
    parameter logic signed [15:0] COEFF       = 16'sd0,
    parameter int unsigned        ACC_W       = 32,
    parameter int unsigned        POWER_SHIFT = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_i,
    input  logic signed [SAMPLE_W-1:0] sample_i,
    input  logic                       sample_valid_i,
    output logic                       busy_o,
    output logic [15:0]                power_o,
    output logic                       valid_o
);

    localparam int unsigned CNT_W = $clog2(N);
    localparam int unsigned PW    = 2 * ACC_W;
    localparam int unsigned PPW   = PW + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_P1,
        S_P2,
        S_P3
    } state_e;

    state_e                    state_q, state_d;
    logic signed [ACC_W-1:0]   s1_q, s1_d;
    logic signed [ACC_W-1:0]   s2_q, s2_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic signed [ACC_W-1:0]   m_q, m_d;
    logic signed [PW-1:0]      a_q, a_d;
    logic signed [PW-1:0]      b_q, b_d;
    logic signed [PW-1:0]      c_q, c_d;
    logic [15:0]               power_q, power_d;
    logic                      valid_q, valid_d;
    logic                      busy_q, busy_d;

    logic signed [PW-1:0]      cs1_full;
    logic signed [ACC_W-1:0]   cs1;
    logic signed [ACC_W-1:0]   s0;
    logic signed [PPW-1:0]     p_raw;
    logic [PPW-1:0]            p_pos;
    logic [PPW-1:0]            p_shr;
    logic [15:0]               p_sat;

    // Recursion datapath: COEFF is Q2.14, so the product is rescaled by 14 bits.
    assign cs1_full = PW'(COEFF) * PW'(s1_q);
    assign cs1      = ACC_W'(cs1_full >>> 14);
    assign s0       = ACC_W'(sample_i) + cs1 - s2_q;

    // Power = s1^2 + s2^2 - m*s2, clamped at zero, scaled, then saturated to 16 bits.
    assign p_raw = PPW'(a_q) + PPW'(b_q) - PPW'(c_q);
    assign p_pos = p_raw[PPW-1] ? '0 : p_raw;
    assign p_shr = p_pos >> POWER_SHIFT;
    assign p_sat = (|p_shr[PPW-1:16]) ? 16'hFFFF : p_shr[15:0];

    always_comb begin
        state_d = state_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        cnt_d   = cnt_q;
        m_d     = m_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        power_d = power_q;
        valid_d = 1'b0;
        busy_d  = busy_q;
        case (state_q)
            S_IDLE: begin
                // busy stays high through the result cycle, then follows start.
                busy_d = start_i;
                if (start_i) begin
                    s1_d    = '0;
                    s2_d    = '0;
                    cnt_d   = '0;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (sample_valid_i) begin
                    s2_d  = s1_q;
                    s1_d  = s0;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(N - 1)) begin
                        state_d = S_P1;
                    end
                end
            end
            S_P1: begin
                m_d     = cs1;
                a_d     = PW'(s1_q) * PW'(s1_q);
                state_d = S_P2;
            end
            S_P2: begin
                b_d     = PW'(s2_q) * PW'(s2_q);
                c_d     = PW'(m_q) * PW'(s2_q);
                state_d = S_P3;
            end
            S_P3: begin
                power_d = p_sat;
                valid_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            s1_q    <= '0;
            s2_q    <= '0;
            cnt_q   <= '0;
            m_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            power_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            power_q <= power_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign busy_o  = busy_q;
    assign power_o = power_q;
    assign valid_o = valid_q;

endmodule

// File: tb/tb_goertzel_power.sv
// Bench for goertzel_power (N=8, COEFF=0): directed tone/DC/saturation/reset cases
// plus random sample sets, all scored against a plain-arithmetic Goertzel model.
module tb_goertzel_power;

    localparam int unsigned N        = 8;
    localparam int unsigned SAMPLE_W = 12;
    localparam int unsigned ACC_W    = 32;
    localparam int unsigned SHIFT    = 8;
    localparam logic signed [15:0] COEFF = 16'sd0;

    typedef int samples_t[N];

    logic                       clk;
    logic                       rst;
    logic                       start_i;
    logic signed [SAMPLE_W-1:0] sample_i;
    logic                       sample_valid_i;
    logic                       busy_o;
    logic [15:0]                power_o;
    logic                       valid_o;

    int n_checks;
    int n_fail;
    int vpulses;
    int exp_power;

    goertzel_power #(
        .N(N), .SAMPLE_W(SAMPLE_W), .COEFF(COEFF), .ACC_W(ACC_W), .POWER_SHIFT(SHIFT)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .sample_i(sample_i),
        .sample_valid_i(sample_valid_i), .busy_o(busy_o), .power_o(power_o), .valid_o(valid_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (valid_o === 1'b1) vpulses++;
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: Goertzel recursion and power formula in 64-bit integers, wrap at 32.
    function automatic int ref_power(input samples_t xs);
        longint s1 = 0;
        longint s2 = 0;
        longint s0, m, a, b, c, p;
        for (int i = 0; i < N; i++) begin
            m  = (longint'(COEFF) * s1) >>> 14;
            s0 = longint'(int'(longint'(xs[i]) + m - s2));
            s2 = s1;
            s1 = s0;
        end
        m = (longint'(COEFF) * s1) >>> 14;
        a = s1 * s1;
        b = s2 * s2;
        c = m * s2;
        p = a + b - c;
        if (p < 0) p = 0;
        p = p >>> SHIFT;
        if (p > 65535) p = 65535;
        return int'(p);
    endfunction

    function automatic samples_t mk_tone(input int amp);
        samples_t xs;
        for (int i = 0; i < N; i++) begin
            case (i % 4)
                0:       xs[i] = amp;
                2:       xs[i] = -amp;
                default: xs[i] = 0;
            endcase
        end
        return xs;
    endfunction

    function automatic samples_t mk_const(input int v);
        samples_t xs;
        for (int i = 0; i < N; i++) xs[i] = v;
        return xs;
    endfunction

    // One measurement; optional gapped valid, stray starts, and a back-to-back restart.
    task automatic run_meas(input string tag, input samples_t xs, input bit gap,
                            input bit mid_start, input bit p3_start,
                            input bit skip_start, input bit btb);
        int exp_p;
        int v0;
        exp_p = ref_power(xs);
        v0    = vpulses;
        if (!skip_start) begin
            start_i        = 1'b1;
            sample_valid_i = 1'b1;
            sample_i       = SAMPLE_W'($urandom);
            step();
            start_i = 1'b0;
            check({tag, "/busy_start"}, longint'(busy_o), 1);
        end
        for (int i = 0; i < N; i++) begin
            sample_i       = SAMPLE_W'(xs[i]);
            sample_valid_i = 1'b1;
            step();
            if (gap && i < N - 1) begin
                sample_valid_i = 1'b0;
                sample_i       = SAMPLE_W'($urandom);
                start_i        = mid_start && (i == 3);
                step();
                start_i = 1'b0;
            end
        end
        check({tag, "/valid_e0"}, longint'(valid_o), 0);
        check({tag, "/held_e0"}, longint'(power_o), longint'(exp_power));
        sample_valid_i = 1'b1;
        sample_i       = SAMPLE_W'($urandom);
        step();
        check({tag, "/valid_e1"}, longint'(valid_o), 0);
        sample_i = SAMPLE_W'($urandom);
        step();
        check({tag, "/valid_e2"}, longint'(valid_o), 0);
        start_i = p3_start;
        step();
        start_i = 1'b0;
        check({tag, "/valid_e3"}, longint'(valid_o), 1);
        check({tag, "/power"}, longint'(power_o), longint'(exp_p));
        check({tag, "/busy_e3"}, longint'(busy_o), 1);
        start_i  = btb;
        sample_i = SAMPLE_W'($urandom);
        step();
        start_i = 1'b0;
        sample_valid_i = 1'b0;
        check({tag, "/valid_e4"}, longint'(valid_o), 0);
        check({tag, "/busy_e4"}, longint'(busy_o), longint'(btb));
        check({tag, "/pulses"}, longint'(vpulses - v0), 1);
        exp_power = exp_p;
    endtask

    initial begin
        samples_t xs;
        int v0;
        n_checks       = 0;
        n_fail         = 0;
        vpulses        = 0;
        exp_power      = 0;
        rst            = 1'b0;
        start_i        = 1'b0;
        sample_valid_i = 1'b0;
        sample_i       = '0;
        step();
        step();
        check("reset/busy", longint'(busy_o), 0);
        check("reset/valid", longint'(valid_o), 0);
        check("reset/power", longint'(power_o), 0);
        rst = 1'b1;
        sample_valid_i = 1'b1;
        step();
        step();
        check("idle/busy", longint'(busy_o), 0);

        run_meas("tone", mk_tone(1000), 0, 0, 0, 0, 0);
        check("tone/value", longint'(power_o), 62500);
        run_meas("dc", mk_const(1000), 0, 0, 0, 0, 0);
        run_meas("zero", mk_const(0), 0, 0, 0, 0, 0);
        run_meas("sat", mk_tone(2047), 0, 0, 0, 0, 0);
        check("sat/value", longint'(power_o), 65535);
        run_meas("gap", mk_tone(1000), 1, 1, 1, 0, 0);

        // Asynchronous reset partway through accumulation.
        start_i        = 1'b1;
        sample_valid_i = 1'b0;
        step();
        start_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sample_i       = SAMPLE_W'(1000);
            sample_valid_i = 1'b1;
            step();
        end
        v0  = vpulses;
        rst = 1'b0;
        #1;
        check("rst_mid/busy", longint'(busy_o), 0);
        check("rst_mid/valid", longint'(valid_o), 0);
        check("rst_mid/power", longint'(power_o), 0);
        exp_power = 0;
        step();
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            sample_valid_i = 1'b1;
            sample_i       = SAMPLE_W'($urandom);
            step();
        end
        check("rst_mid/no_valid", longint'(vpulses - v0), 0);
        check("rst_mid/busy_after", longint'(busy_o), 0);
        run_meas("fresh", mk_tone(1000), 0, 0, 0, 0, 0);

        run_meas("btb1", mk_tone(500), 0, 0, 0, 0, 1);
        run_meas("btb2", mk_tone(1000), 0, 0, 0, 1, 0);

        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < N; i++) xs[i] = int'($urandom_range(0, 4095)) - 2048;
            run_meas($sformatf("rand%0d", t), xs, 1'($urandom), 1'($urandom), 1'($urandom), 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
